// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// PWM brightness per slot, anti-ghost blank, per-digit blink.
`timescale 1ns/1ps

package myPkg;
    // Active-low segments, bit 7 = dp (kept off).
    function automatic logic [7:0] seg_drv(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction
endpackage

module seg_scan_ctrl #(
    parameter int         NUM_SEG      = 6,
    parameter int         CLK_DIV      = 1000,
    parameter int         BLINK_FRAMES = 64,
    parameter logic [7:0] SEG_OFF      = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_SEG)-1:0] wr_idx,
    input  logic [3:0]                 wr_data,
    input  logic [3:0]                 bright,
    input  logic [NUM_SEG-1:0]         blink_mask,
    output logic [NUM_SEG-1:0]         dig_sel,
    output logic [7:0]                 seg_out,
    output logic                       frame_start
);
    import myPkg::*;

    localparam int DW = $clog2(NUM_SEG);
    localparam int PW = $clog2(CLK_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    pre;
    logic [3:0]       sub;
    logic [DW-1:0]    dig;
    logic [FW-1:0]    frm;
    logic             phase;
    logic [3:0]       store [NUM_SEG];

    logic             run, tick, dig_last, wrap, lit;
    logic [NUM_SEG-1:0] dig_sel_nx;
    logic [7:0]       seg_nx;
    logic             fs_nx;

    assign run      = (state == SCAN) && en;
    assign tick     = (state == SCAN) && (pre == PW'(CLK_DIV - 1));
    assign dig_last = (dig == DW'(NUM_SEG - 1));
    assign wrap     = tick && (sub == 4'hF) && dig_last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en)  state_nx = SCAN;
            SCAN:    if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan counters only run while scanning; any exit clears them.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            pre <= '0;
            sub <= '0;
            dig <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                sub <= sub + 4'd1;
                if (sub == 4'hF)
                    dig <= dig_last ? '0 : dig + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm   <= '0;
            phase <= 1'b0;
        end else if (run && wrap) begin
            if (frm == FW'(BLINK_FRAMES - 1)) begin
                frm   <= '0;
                phase <= ~phase;
            end else begin
                frm <= frm + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) store[i] <= 4'h0;
        end else if (wr_en && ({1'b0, wr_idx} < (DW+1)'(NUM_SEG))) begin
            store[wr_idx] <= wr_data;
        end
    end

    // Sub 0 is always blank so the digit change never ghosts.
    always_comb begin
        lit = run && (sub != 4'd0) && (sub <= bright)
              && !(phase && blink_mask[dig]);
        dig_sel_nx = lit ? (NUM_SEG'(1) << dig) : '0;
        seg_nx     = lit ? seg_drv(store[dig]) : SEG_OFF;
        fs_nx      = run && (pre == '0) && (sub == 4'd0) && (dig == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_sel     <= '0;
            seg_out     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            dig_sel     <= dig_sel_nx;
            seg_out     <= seg_nx;
            frame_start <= fs_nx;
        end
    end

endmodule
